// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, instruction field positions and issue FSM encoding
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_XOR = 4'd1,
        OP_OR  = 4'd2,
        OP_AND = 4'd3,
        OP_SEQ = 4'd4,
        OP_SLT = 4'd5,
        OP_SL  = 4'd6,
        OP_SR  = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } issue_state_e;

    localparam int INSTR_W    = 16;
    localparam int REG_ADDR_W = 3;
    localparam int OP_MSB     = 15;
    localparam int OP_LSB     = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 9;
    localparam int RS1_MSB    = 8;
    localparam int RS1_LSB    = 6;
    localparam int IMM_BIT    = 5;
    localparam int IMM5_MSB   = 4;
    localparam int IMM5_LSB   = 0;
    localparam int RS2_MSB    = 2;

    // Opcodes 8..15 are reserved and must never reach the ALU.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= 4'(OP_SR));
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 8xN architectural register file, r0 hardwired to zero
module alu_regfile
    import alu_pkg::*;
#(
    parameter int N    = 16,
    parameter int REGS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [N-1:0]          i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr1,
    input  logic [REG_ADDR_W-1:0] i_raddr2,
    input  logic [REG_ADDR_W-1:0] i_dbg_addr,
    output logic [N-1:0]          o_rdata1,
    output logic [N-1:0]          o_rdata2,
    output logic [N-1:0]          o_dbg_data
);

    logic [N-1:0] r_regs [REGS];

    // r0 is only ever cleared, so it reads as zero without a read-side mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1   = r_regs[i_raddr1];
    assign o_rdata2   = r_regs[i_raddr2];
    assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - instruction issue, operand fetch and writeback around a combinational ALU
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int N    = 16,
    parameter int REGS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instr,
    output logic [N-1:0]          alu_a,
    output logic [N-1:0]          alu_b,
    output logic [3:0]            alu_op,
    input  logic [N-1:0]          alu_out,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [N-1:0]          wb_data,
    output logic                  illegal,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [N-1:0]          dbg_data
);

    issue_state_e r_state;
    issue_state_e w_next_state;

    logic [3:0]            w_op;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic                  w_imm;
    logic [4:0]            w_imm5;
    logic                  w_legal;
    logic                  w_accept;
    logic                  w_rf_we;
    logic [N-1:0]          w_rs1_data;
    logic [N-1:0]          w_rs2_data;
    logic [N-1:0]          w_operand_b;

    logic [N-1:0]          r_alu_a;
    logic [N-1:0]          r_alu_b;
    logic [3:0]            r_alu_op;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_wb_valid;
    logic [REG_ADDR_W-1:0] r_wb_addr;
    logic [N-1:0]          r_wb_data;
    logic                  r_illegal;

    assign w_op    = instr[OP_MSB:OP_LSB];
    assign w_rd    = instr[RD_MSB:RD_LSB];
    assign w_rs1   = instr[RS1_MSB:RS1_LSB];
    assign w_rs2   = instr[RS2_MSB:IMM5_LSB];
    assign w_imm   = instr[IMM_BIT];
    assign w_imm5  = instr[IMM5_MSB:IMM5_LSB];
    assign w_legal = op_is_legal(w_op);

    assign w_accept    = instr_valid && (r_state == ST_IDLE);
    assign w_operand_b = w_imm ? {{(N-5){1'b0}}, w_imm5} : w_rs2_data;
    assign w_rf_we     = (r_state == ST_EXEC);

    alu_regfile #(
        .N    (N),
        .REGS (REGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_rf_we),
        .i_waddr    (r_rd),
        .i_wdata    (alu_out),
        .i_raddr1   (w_rs1),
        .i_raddr2   (w_rs2),
        .i_dbg_addr (dbg_addr),
        .o_rdata1   (w_rs1_data),
        .o_rdata2   (w_rs2_data),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        instr_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next_state = w_legal ? ST_EXEC : ST_WB;
                end
            end
            ST_EXEC: w_next_state = ST_WB;
            ST_WB:   w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Illegal opcodes skip EXEC and leave the ALU inputs untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_rd       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rd <= w_rd;
                        if (w_legal) begin
                            r_alu_a  <= w_rs1_data;
                            r_alu_b  <= w_operand_b;
                            r_alu_op <= w_op;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    r_wb_valid <= 1'b1;
                    r_wb_addr  <= r_rd;
                    r_wb_data  <= alu_out;
                end
                ST_WB: begin
                    r_wb_valid <= 1'b0;
                    r_illegal  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign wb_valid = r_wb_valid;
    assign wb_addr  = r_wb_addr;
    assign wb_data  = r_wb_data;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized self-checking bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [15:0]  instr = '0;
    logic [N-1:0] alu_a, alu_b, alu_out, wb_data, dbg_data;
    logic [3:0]   alu_op;
    logic         wb_valid, illegal;
    logic [2:0]   wb_addr;
    logic [2:0]   dbg_addr = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.N(N), .REGS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    function automatic logic [N-1:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a ^ b;
            4'd2:    return a | b;
            4'd3:    return a & b;
            4'd4:    return (a == b) ? 16'd1 : 16'd0;
            4'd5:    return (a < b) ? 16'd1 : 16'd0;
            4'd6:    return a << b;
            4'd7:    return a >> b;
            default: return '0;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_op, alu_a, alu_b);

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   op;
        logic [3:0]   n_wb;
        logic [3:0]   n_ill;
        logic [2:0]   wba;
        logic [N-1:0] wbd;
        logic [3:0]   lat;
    } obs_t;

    logic [N-1:0] m_regs [8];
    logic [N-1:0] m_a, m_b, m_wbd;
    logic [3:0]   m_op;
    logic [2:0]   m_wba;

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int imm, input int lo);
        return {op[3:0], rd[2:0], rs1[2:0], imm[0], lo[4:0]};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) m_regs[r] = '0;
        m_a = '0; m_b = '0; m_op = '0; m_wba = '0; m_wbd = '0;
    endtask

    task automatic predict(input logic [15:0] ins, output obs_t e);
        logic [3:0]   op;
        logic [2:0]   rd;
        logic [4:0]   lo;
        logic [N-1:0] res;
        op = ins[15:12];
        rd = ins[11:9];
        lo = ins[4:0];
        e  = '0;
        if (op > 4'd7) begin
            e.n_ill = 4'd1;
            e.lat   = 4'd2;
        end else begin
            m_a  = m_regs[ins[8:6]];
            m_b  = ins[5] ? {11'd0, lo} : m_regs[lo[2:0]];
            m_op = op;
            res  = alu_fn(op, m_a, m_b);
            m_wba = rd;
            m_wbd = res;
            if (rd != 3'd0) m_regs[rd] = res;
            e.n_wb = 4'd1;
            e.lat  = 4'd3;
        end
        e.a = m_a; e.b = m_b; e.op = m_op; e.wba = m_wba; e.wbd = m_wbd;
    endtask

    task automatic run_instr(input logic [15:0] ins, output obs_t o);
        int k;
        o = '0;
        k = 0;
        @(negedge clk);
        while (!instr_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        o.a = alu_a; o.b = alu_b; o.op = alu_op; o.lat = 4'd1;
        k = 0;
        while (!instr_ready && k < 12) begin
            if (wb_valid) o.n_wb  = o.n_wb + 4'd1;
            if (illegal)  o.n_ill = o.n_ill + 4'd1;
            @(negedge clk);
            o.lat = o.lat + 4'd1;
            k++;
        end
        if (wb_valid) o.n_wb  = o.n_wb + 4'd1;
        if (illegal)  o.n_ill = o.n_ill + 4'd1;
        o.wba = wb_addr; o.wbd = wb_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_tests++;
        if ({instr_ready, alu_a, alu_b, alu_op, wb_valid, wb_addr, wb_data, illegal} !==
            {1'b1, 16'd0, 16'd0, 4'd0, 1'b0, 3'd0, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b a=%h b=%h op=%h wbv=%b wba=%h wbd=%h ill=%b expected rdy=1 rest 0",
                     instr_ready, alu_a, alu_b, alu_op, wb_valid, wb_addr, wb_data, illegal);
        end
        for (int r = 0; r < 8; r++) begin
            dbg_addr = r[2:0];
            #1;
            n_tests++;
            if (dbg_data !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_reg r%0d: got %h expected 0000", r, dbg_data);
            end
        end
    endtask

    task automatic test_add_imm();
        obs_t o, e, lit;
        logic [15:0] ins;
        ins = enc(0, 1, 0, 1, 5);
        run_instr(ins, o);
        predict(ins, e);
        lit = '{a: 16'd0, b: 16'd5, op: 4'd0, n_wb: 4'd1, n_ill: 4'd0, wba: 3'd1, wbd: 16'd5, lat: 4'd3};
        n_tests++;
        if (o !== e || o !== lit) begin
            n_fail++;
            $display("FAIL add_imm: got %h expected %h", o, lit);
        end
        dbg_addr = 3'd1;
        #1;
        n_tests++;
        if (dbg_data !== 16'd5) begin
            n_fail++;
            $display("FAIL add_imm_r1: got %h expected 0005", dbg_data);
        end
    endtask

    task automatic test_register_ops();
        logic [15:0]  prog [5];
        logic [N-1:0] want [4];
        obs_t o, e;
        prog[0] = enc(0, 2, 0, 1, 3);
        prog[1] = enc(5, 3, 2, 0, 1);
        prog[2] = enc(1, 4, 1, 0, 2);
        prog[3] = enc(7, 5, 1, 1, 1);
        prog[4] = enc(6, 6, 1, 1, 4);
        want[0] = 16'd1; want[1] = 16'd6; want[2] = 16'd2; want[3] = 16'h0050;
        for (int i = 0; i < 5; i++) begin
            run_instr(prog[i], o);
            predict(prog[i], e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL regop_%0d: got %h expected %h", i, o, e);
            end
        end
        for (int r = 3; r <= 6; r++) begin
            dbg_addr = r[2:0];
            #1;
            n_tests++;
            if (dbg_data !== want[r-3]) begin
                n_fail++;
                $display("FAIL regop_r%0d: got %h expected %h", r, dbg_data, want[r-3]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] prog [9];
        obs_t o, e;
        prog[0] = enc(2, 1, 0, 1, 31);
        prog[1] = enc(6, 1, 1, 1, 5);
        prog[2] = enc(2, 1, 1, 1, 31);
        prog[3] = enc(6, 1, 1, 1, 5);
        prog[4] = enc(2, 1, 1, 1, 31);
        prog[5] = enc(6, 1, 1, 1, 1);
        prog[6] = enc(2, 1, 1, 1, 1);
        prog[7] = enc(0, 1, 1, 1, 1);
        prog[8] = enc(4, 2, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            if (i == 7) begin
                dbg_addr = 3'd1;
                #1;
                n_tests++;
                if (dbg_data !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL wrap_r1_ones: got %h expected ffff", dbg_data);
                end
            end
            run_instr(prog[i], o);
            predict(prog[i], e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap_%0d: got %h expected %h", i, o, e);
            end
            if (i == 7) begin
                n_tests++;
                if (o.wbd !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL wrap_add: got %h expected 0000", o.wbd);
                end
            end
        end
        dbg_addr = 3'd2;
        #1;
        n_tests++;
        if (dbg_data !== 16'd1) begin
            n_fail++;
            $display("FAIL wrap_seq_r2: got %h expected 0001", dbg_data);
        end
    endtask

    task automatic test_illegal_and_r0();
        obs_t o, e;
        logic [15:0] ins;
        logic [3:0]  prev_op;
        prev_op = m_op;
        ins = enc(9, 2, 1, 1, 3);
        run_instr(ins, o);
        predict(ins, e);
        n_tests++;
        if (o !== e || o.n_ill !== 4'd1 || o.n_wb !== 4'd0 || o.op !== prev_op) begin
            n_fail++;
            $display("FAIL illegal_op: got %h expected %h", o, e);
        end
        for (int r = 0; r < 8; r++) begin
            dbg_addr = r[2:0];
            #1;
            n_tests++;
            if (dbg_data !== m_regs[r]) begin
                n_fail++;
                $display("FAIL illegal_reg r%0d: got %h expected %h", r, dbg_data, m_regs[r]);
            end
        end
        ins = enc(0, 0, 0, 1, 7);
        run_instr(ins, o);
        predict(ins, e);
        n_tests++;
        if (o !== e || o.wbd !== 16'd7 || o.wba !== 3'd0) begin
            n_fail++;
            $display("FAIL r0_write: got %h expected %h", o, e);
        end
        dbg_addr = 3'd0;
        #1;
        n_tests++;
        if (dbg_data !== 16'd0) begin
            n_fail++;
            $display("FAIL r0_reads_zero: got %h expected 0000", dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0]  seq [3];
        logic [N-1:0] exp_d [3];
        logic [N-1:0] wbq [$];
        int           acc [3];
        int           i;
        obs_t         e;
        seq[0] = enc(0, 1, 0, 1, 7);
        seq[1] = enc(0, 2, 1, 1, 3);
        seq[2] = enc(1, 3, 2, 0, 1);
        for (int k = 0; k < 3; k++) begin
            predict(seq[k], e);
            exp_d[k] = e.wbd;
            acc[k] = -100;
        end
        wbq.delete();
        i = 0;
        @(negedge clk);
        instr = seq[0];
        instr_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (wb_valid) wbq.push_back(wb_data);
            if (instr_ready && i < 3) begin
                acc[i] = c;
                i++;
                @(posedge clk);
                #1;
                if (i < 3) instr = seq[i];
                else instr_valid = 1'b0;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            n_tests++;
            if (acc[k] - acc[k-1] !== 3) begin
                n_fail++;
                $display("FAIL b2b_spacing_%0d: got %0d cycles expected 3", k, acc[k] - acc[k-1]);
            end
        end
        n_tests++;
        if (wbq.size() !== 3) begin
            n_fail++;
            $display("FAIL b2b_wb_count: got %0d expected 3", wbq.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (wbq[k] !== exp_d[k]) begin
                    n_fail++;
                    $display("FAIL b2b_wb_%0d: got %h expected %h", k, wbq[k], exp_d[k]);
                end
            end
        end
        dbg_addr = 3'd3;
        #1;
        n_tests++;
        if (dbg_data !== 16'd13) begin
            n_fail++;
            $display("FAIL b2b_r3: got %h expected 000d", dbg_data);
        end
    endtask

    task automatic test_reset_mid_exec();
        int k;
        k = 0;
        @(negedge clk);
        while (!instr_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        instr = enc(0, 1, 0, 1, 9);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (wb_valid !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec_pulse: got wbv=%b ill=%b expected 0 0", wb_valid, illegal);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        dbg_addr = 3'd1;
        #1;
        n_tests++;
        if ({instr_ready, wb_valid, wb_addr, wb_data, dbg_data} !== {1'b1, 1'b0, 3'd0, 16'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL rst_exec_after: got rdy=%b wbv=%b wba=%h wbd=%h r1=%h expected 1 0 0 0000 0000",
                     instr_ready, wb_valid, wb_addr, wb_data, dbg_data);
        end
    endtask

    task automatic test_random();
        obs_t        o, e;
        logic [15:0] ins;
        int          op;
        for (int i = 0; i < 60; i++) begin
            op  = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            ins = enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31));
            run_instr(ins, o);
            predict(ins, e);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL random_%0d instr=%h: got %h expected %h", i, ins, o, e);
            end
            if (i % 15 == 14) begin
                for (int r = 0; r < 8; r++) begin
                    dbg_addr = r[2:0];
                    #1;
                    n_tests++;
                    if (dbg_data !== m_regs[r]) begin
                        n_fail++;
                        $display("FAIL random_reg r%0d: got %h expected %h", r, dbg_data, m_regs[r]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_register_ops();
        test_wrap();
        test_illegal_and_r0();
        test_back_to_back();
        test_reset_mid_exec();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
